// File: rtl/rename.sv
// -----------------------------------------------------------------------------
// rename -- register rename stage.
//
// Purpose:
//   Maps the architectural sources and destination of one uop per cycle onto
//   physical register tags through a 32-entry rename map table (RAT). It also
//   reads the operand values and busy bits for the source tags, and writes one
//   filled entry per cycle into the reservation station.
//
// Ports:
//   clk                  in   clock, all state on rising edge
//   rst                  in   synchronous active-high reset (overrides en)
//   en                   in   rename uop_in this cycle
//   uop_in               in   incoming uop (uop_ic.rd/rs1/rs2 are architectural)
//   busy_table_rd1_addr  out  physical tag of rs1 to the busy table
//   busy_table_data1_in  in   busy bit for rd1 address, same cycle
//   busy_table_rd2_addr  out  physical tag of rs2 to the busy table
//   busy_table_data2_in  in   busy bit for rd2 address, same cycle
//   phy_rf_rs1_addr_out  out  physical tag of rs1 to the register file
//   phy_rf_rs1_data_in   in   rs1 register value, same cycle
//   phy_rf_rs2_addr_out  out  physical tag of rs2 to the register file
//   phy_rf_rs2_data_in   in   rs2 register value, same cycle
//   res_st_wr_en_out     out  reservation-station write strobe (registered)
//   res_st_wr_addr_out   out  reservation-station entry index (registered)
//   res_st_data_out      out  reservation-station entry payload (registered)
//
// Handshake: there is no valid/ready pair. en is a one-cycle strobe that the
// stage always accepts; exactly one cycle later res_st_wr_en_out pulses with
// the filled entry. The reservation station cannot push back.
// -----------------------------------------------------------------------------

package qu_common;
  localparam int PHY_RF_ADDR_WIDTH = 6;
  localparam int RES_ST_ADDR_WIDTH = 3;

  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_addr_t;
  typedef logic [RES_ST_ADDR_WIDTH-1:0] res_st_addr_t;
endpackage

package qu_uop;
  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } uop_ic_t;

  typedef struct packed {
    uop_ic_t uop_ic;
  } uop_t;

  typedef struct packed {
    logic                 valid;
    uop_t                 uop;
    qu_common::phy_addr_t rd_phy;
    qu_common::phy_addr_t rs1_phy;
    qu_common::phy_addr_t rs2_phy;
    logic [31:0]          rs1_val;
    logic [31:0]          rs2_val;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
  } res_st_cell_t;
endpackage

module rename
  import qu_common::*;
  import qu_uop::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  uop_t                         uop_in,
  output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_rd1_addr,
  input  logic                         busy_table_data1_in,
  output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_rd2_addr,
  input  logic                         busy_table_data2_in,
  output logic [PHY_RF_ADDR_WIDTH-1:0] phy_rf_rs1_addr_out,
  input  logic [31:0]                  phy_rf_rs1_data_in,
  output logic [PHY_RF_ADDR_WIDTH-1:0] phy_rf_rs2_addr_out,
  input  logic [31:0]                  phy_rf_rs2_data_in,
  output logic                         res_st_wr_en_out,
  output res_st_addr_t                 res_st_wr_addr_out,
  output res_st_cell_t                 res_st_data_out
);

  localparam int        P         = 1 << PHY_RF_ADDR_WIDTH;
  // Tags 0..31 are the identity mapping held by the RAT after reset, so fresh
  // tags are handed out only from the upper range.
  localparam phy_addr_t FIRST_TAG = phy_addr_t'(32);
  localparam phy_addr_t LAST_TAG  = phy_addr_t'(P - 1);

  phy_addr_t    rat_q [32];
  phy_addr_t    alloc_ptr_q, alloc_ptr_d;
  res_st_addr_t rs_ptr_q;
  logic         wr_en_q;
  res_st_addr_t wr_addr_q;
  res_st_cell_t data_q, data_d;

  phy_addr_t    rs1_phy, rs2_phy;
  logic         alloc;

  // Sources read the RAT as it stands before this cycle's destination write,
  // which is what gives rs == rd inside one uop the older mapping.
  assign rs1_phy = rat_q[uop_in.uop_ic.rs1];
  assign rs2_phy = rat_q[uop_in.uop_ic.rs2];

  assign busy_table_rd1_addr = rs1_phy;
  assign busy_table_rd2_addr = rs2_phy;
  assign phy_rf_rs1_addr_out = rs1_phy;
  assign phy_rf_rs2_addr_out = rs2_phy;

  // x0 never gets a tag: it stays hard-wired to physical register 0.
  assign alloc = en && (uop_in.uop_ic.rd != 5'd0);

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    if (alloc) begin
      alloc_ptr_d = (alloc_ptr_q == LAST_TAG) ? FIRST_TAG
                                              : alloc_ptr_q + phy_addr_t'(1);
    end
  end

  // Idle cycles keep the previous payload but drop its valid bit.
  always_comb begin
    data_d       = data_q;
    data_d.valid = 1'b0;
    if (en) begin
      data_d.valid   = 1'b1;
      data_d.uop     = uop_in;
      data_d.rd_phy  = alloc ? alloc_ptr_q : phy_addr_t'(0);
      data_d.rs1_phy = rs1_phy;
      data_d.rs2_phy = rs2_phy;
      if (uop_in.uop_ic.rs1 == 5'd0) begin
        data_d.rs1_val = 32'd0;
        data_d.rs1_rdy = 1'b1;
      end else begin
        data_d.rs1_val = phy_rf_rs1_data_in;
        data_d.rs1_rdy = !busy_table_data1_in;
      end
      if (uop_in.uop_ic.rs2 == 5'd0) begin
        data_d.rs2_val = 32'd0;
        data_d.rs2_rdy = 1'b1;
      end else begin
        data_d.rs2_val = phy_rf_rs2_data_in;
        data_d.rs2_rdy = !busy_table_data2_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rat_q[i] <= phy_addr_t'(i);
      end
      alloc_ptr_q <= FIRST_TAG;
      rs_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      data_q      <= '0;
    end else begin
      if (alloc) begin
        rat_q[uop_in.uop_ic.rd] <= alloc_ptr_q;
      end
      alloc_ptr_q <= alloc_ptr_d;
      wr_en_q     <= en;
      data_q      <= data_d;
      if (en) begin
        wr_addr_q <= rs_ptr_q;
        // R is a power of two, so the natural wrap is R-1 -> 0.
        rs_ptr_q  <= rs_ptr_q + res_st_addr_t'(1);
      end
    end
  end

  assign res_st_wr_en_out   = wr_en_q;
  assign res_st_wr_addr_out = wr_addr_q;
  assign res_st_data_out    = data_q;

endmodule

// File: tb/tb_rename.sv
// -----------------------------------------------------------------------------
// tb_rename -- self-checking bench for the rename stage.
// Reference model: an integer RAT array, an allocation counter and an RS
// counter, updated from the rename rules; expected outputs go through exp_q.
// -----------------------------------------------------------------------------
module tb_rename;
  import qu_common::*;
  import qu_uop::*;

  localparam int RSW = RES_ST_ADDR_WIDTH;
  localparam int R   = 1 << RES_ST_ADDR_WIDTH;
  localparam int P   = 1 << PHY_RF_ADDR_WIDTH;
  localparam int CW  = $bits(res_st_cell_t);
  localparam int EW  = 1 + RSW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst;
  logic                         en;
  uop_t                         uop_in;
  logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_rd1_addr, busy_table_rd2_addr;
  logic                         busy_table_data1_in, busy_table_data2_in;
  logic [PHY_RF_ADDR_WIDTH-1:0] phy_rf_rs1_addr_out, phy_rf_rs2_addr_out;
  logic [31:0]                  phy_rf_rs1_data_in, phy_rf_rs2_data_in;
  logic                         res_st_wr_en_out;
  res_st_addr_t                 res_st_wr_addr_out;
  res_st_cell_t                 res_st_data_out;

  rename dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .uop_in              (uop_in),
    .busy_table_rd1_addr (busy_table_rd1_addr),
    .busy_table_data1_in (busy_table_data1_in),
    .busy_table_rd2_addr (busy_table_rd2_addr),
    .busy_table_data2_in (busy_table_data2_in),
    .phy_rf_rs1_addr_out (phy_rf_rs1_addr_out),
    .phy_rf_rs1_data_in  (phy_rf_rs1_data_in),
    .phy_rf_rs2_addr_out (phy_rf_rs2_addr_out),
    .phy_rf_rs2_data_in  (phy_rf_rs2_data_in),
    .res_st_wr_en_out    (res_st_wr_en_out),
    .res_st_wr_addr_out  (res_st_wr_addr_out),
    .res_st_data_out     (res_st_data_out)
  );

  // ---------------- reference model + scoreboard ----------------
  int           m_rat [32];
  int           m_alloc;
  int           m_rs;
  res_st_cell_t m_last;
  res_st_addr_t m_last_addr;
  logic [EW-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  logic         e_en;
  res_st_addr_t e_addr;
  res_st_cell_t e_cell;

  // Drive inputs (called just after a rising edge).
  task automatic drive(input logic e, input int rd, input int rs1, input int rs2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic b1, input logic b2);
    en                  = e;
    uop_in.uop_ic.pc    = $urandom;
    uop_in.uop_ic.op    = 10'($urandom);
    uop_in.uop_ic.rd    = 5'(rd);
    uop_in.uop_ic.rs1   = 5'(rs1);
    uop_in.uop_ic.rs2   = 5'(rs2);
    phy_rf_rs1_data_in  = d1;
    phy_rf_rs2_data_in  = d2;
    busy_table_data1_in = b1;
    busy_table_data2_in = b2;
  endtask

  // Predict the result of the upcoming edge from the driven inputs, then
  // advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    res_st_cell_t c;
    logic         we;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rat[i] = i;
      m_alloc     = 32;
      m_rs        = 0;
      m_last      = '0;
      m_last_addr = '0;
      we          = 1'b0;
    end else if (en) begin
      c.valid   = 1'b1;
      c.uop     = uop_in;
      c.rs1_phy = phy_addr_t'(m_rat[uop_in.uop_ic.rs1]);
      c.rs2_phy = phy_addr_t'(m_rat[uop_in.uop_ic.rs2]);
      c.rs1_val = (uop_in.uop_ic.rs1 == 0) ? 32'd0 : phy_rf_rs1_data_in;
      c.rs2_val = (uop_in.uop_ic.rs2 == 0) ? 32'd0 : phy_rf_rs2_data_in;
      c.rs1_rdy = (uop_in.uop_ic.rs1 == 0) ? 1'b1 : !busy_table_data1_in;
      c.rs2_rdy = (uop_in.uop_ic.rs2 == 0) ? 1'b1 : !busy_table_data2_in;
      if (uop_in.uop_ic.rd == 0) begin
        c.rd_phy = '0;
      end else begin
        c.rd_phy = phy_addr_t'(m_alloc);
        m_rat[uop_in.uop_ic.rd] = m_alloc;
        m_alloc = (m_alloc == P - 1) ? 32 : m_alloc + 1;
      end
      m_last      = c;
      m_last_addr = res_st_addr_t'(m_rs);
      m_rs        = (m_rs + 1) % R;
      we          = 1'b1;
    end else begin
      m_last.valid = 1'b0;
      we           = 1'b0;
    end
    exp_q.push_back({we, m_last_addr, m_last});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    void'(exp_q.pop_front());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 7, 3, 9, 32'h11, 32'h22, 0, 0);
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_wr_en_out !== 1'b0) begin
      bad++; $display("FAIL reset_wr_en got=%b want=0", res_st_wr_en_out);
    end
    total++;
    if (res_st_wr_addr_out !== '0) begin
      bad++; $display("FAIL reset_wr_addr got=%0d want=0", res_st_wr_addr_out);
    end
    total++;
    if (res_st_data_out !== e_cell) begin
      bad++; $display("FAIL reset_data got=%h want=%h", res_st_data_out, e_cell);
    end
    total++;
    if (busy_table_rd1_addr !== phy_addr_t'(3) || phy_rf_rs2_addr_out !== phy_addr_t'(9)) begin
      bad++; $display("FAIL reset_rat_identity got=%0d/%0d want=3/9",
                      busy_table_rd1_addr, phy_rf_rs2_addr_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 4, 8, 12, 32'd2, 32'd4, 0, 0);
    #1;
    total++;
    if (busy_table_rd1_addr !== phy_addr_t'(8) || busy_table_rd2_addr !== phy_addr_t'(12)) begin
      bad++; $display("FAIL basic_rd_addr got=%0d/%0d want=8/12",
                      busy_table_rd1_addr, busy_table_rd2_addr);
    end
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_wr_en_out !== 1'b1 || res_st_wr_addr_out !== res_st_addr_t'(0) ||
        res_st_data_out.rd_phy !== phy_addr_t'(32) || res_st_data_out.rs1_phy !== phy_addr_t'(8) ||
        res_st_data_out.rs2_phy !== phy_addr_t'(12) || res_st_data_out.rs1_val !== 32'd2 ||
        res_st_data_out.rs2_val !== 32'd4 || res_st_data_out.rs1_rdy !== 1'b1 ||
        res_st_data_out.rs2_rdy !== 1'b1 || res_st_data_out.valid !== 1'b1) begin
      bad++; $display("FAIL basic_first got=%b/%0d/%h want wr 1 addr 0 rd_phy 32",
                      res_st_wr_en_out, res_st_wr_addr_out, res_st_data_out);
    end
    total++;
    if (res_st_data_out !== e_cell) begin
      bad++; $display("FAIL basic_first_model got=%h want=%h", res_st_data_out, e_cell);
    end

    drive(1'b1, 16, 20, 24, 32'd5, 32'd6, 0, 0);
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_wr_addr_out !== res_st_addr_t'(1) || res_st_data_out.rd_phy !== phy_addr_t'(33) ||
        res_st_data_out.rs1_val !== 32'd5 || res_st_data_out.rs2_val !== 32'd6) begin
      bad++; $display("FAIL basic_second got=%0d/%0d/%0d/%0d want=1/33/5/6",
                      res_st_wr_addr_out, res_st_data_out.rd_phy,
                      res_st_data_out.rs1_val, res_st_data_out.rs2_val);
    end

    drive(1'b1, 20, 16, 3, 32'd9, 32'd10, 1, 0);
    #1;
    total++;
    if (busy_table_rd1_addr !== phy_addr_t'(33)) begin
      bad++; $display("FAIL basic_renamed_src got=%0d want=33", busy_table_rd1_addr);
    end
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_wr_addr_out !== res_st_addr_t'(2) || res_st_data_out.rd_phy !== phy_addr_t'(34) ||
        res_st_data_out.rs1_rdy !== 1'b0 || res_st_data_out.rs1_phy !== phy_addr_t'(33)) begin
      bad++; $display("FAIL basic_third got=%0d/%0d/%b want=2/34/0",
                      res_st_wr_addr_out, res_st_data_out.rd_phy, res_st_data_out.rs1_rdy);
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    drive(1'b1, 5, 5, 0, 32'd1, 32'd1, 0, 0);
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_data_out.rs1_phy !== phy_addr_t'(5) || res_st_data_out.rd_phy !== phy_addr_t'(32)) begin
      bad++; $display("FAIL same_reg_old_map got=%0d/%0d want=5/32",
                      res_st_data_out.rs1_phy, res_st_data_out.rd_phy);
    end
    drive(1'b1, 6, 5, 5, 32'd1, 32'd1, 0, 0);
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_data_out.rs1_phy !== phy_addr_t'(32) || res_st_data_out.rs2_phy !== phy_addr_t'(32)) begin
      bad++; $display("FAIL same_reg_new_map got=%0d/%0d want=32/32",
                      res_st_data_out.rs1_phy, res_st_data_out.rs2_phy);
    end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i < 33; i++) begin
      drive(1'b1, 1, $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom, $urandom, 1'($urandom), 1'($urandom));
      tick();
      {e_en, e_addr, e_cell} = exp_q.pop_front();
      total++;
      if (res_st_data_out.rd_phy !== phy_addr_t'(32 + (i % 32)) ||
          res_st_wr_addr_out !== res_st_addr_t'(i % R) || res_st_data_out !== e_cell) begin
        bad++; $display("FAIL wrap_%0d got=%0d/%0d want=%0d/%0d", i,
                        res_st_data_out.rd_phy, res_st_wr_addr_out, 32 + (i % 32), i % R);
      end
    end
  endtask

  task automatic test_idle_and_zero();
    logic [5:0] next_tag;
    next_tag = phy_addr_t'(m_alloc);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 9, 9, 9, $urandom, $urandom, 0, 0);
      tick();
      {e_en, e_addr, e_cell} = exp_q.pop_front();
      total++;
      if (res_st_wr_en_out !== 1'b0 || res_st_data_out.valid !== 1'b0 ||
          res_st_data_out !== e_cell || res_st_wr_addr_out !== e_addr) begin
        bad++; $display("FAIL idle_%0d got=%b/%h want=0/%h", i,
                        res_st_wr_en_out, res_st_data_out, e_cell);
      end
    end
    drive(1'b1, 0, 0, 2, 32'd7, 32'd8, 1, 1);
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_data_out.rd_phy !== '0 || res_st_data_out.rs1_val !== 32'd0 ||
        res_st_data_out.rs1_rdy !== 1'b1 || res_st_data_out.rs2_rdy !== 1'b0 ||
        res_st_data_out.rs2_val !== 32'd8) begin
      bad++; $display("FAIL zero_reg got=%h want=%h", res_st_data_out, e_cell);
    end
    drive(1'b1, 2, 1, 1, 32'd1, 32'd1, 0, 0);
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_data_out.rd_phy !== next_tag) begin
      bad++; $display("FAIL no_alloc_when_idle got=%0d want=%0d", res_st_data_out.rd_phy, next_tag);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 3, 4, 5, 32'd1, 32'd2, 0, 0);
    tick();
    void'(exp_q.pop_front());
    rst = 1'b1;
    drive(1'b1, 3, 4, 5, 32'd1, 32'd2, 0, 0);
    tick();
    rst = 1'b0;
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_wr_en_out !== 1'b0 || res_st_data_out !== '0) begin
      bad++; $display("FAIL midreset_discard got=%b/%h want=0/0", res_st_wr_en_out, res_st_data_out);
    end
    drive(1'b1, 3, 3, 0, 32'd1, 32'd2, 0, 0);
    tick();
    {e_en, e_addr, e_cell} = exp_q.pop_front();
    total++;
    if (res_st_data_out.rd_phy !== phy_addr_t'(32) || res_st_wr_addr_out !== '0 ||
        res_st_data_out.rs1_phy !== phy_addr_t'(3)) begin
      bad++; $display("FAIL midreset_first got=%0d/%0d want=32/0",
                      res_st_data_out.rd_phy, res_st_wr_addr_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int rd, rs1, rs2;
      rd  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
      rs1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
      rs2 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
      drive($urandom_range(0, 3) != 0, rd, rs1, rs2, $urandom, $urandom,
            1'($urandom), 1'($urandom));
      #1;
      total++;
      if (busy_table_rd1_addr !== phy_addr_t'(m_rat[rs1]) || phy_rf_rs1_addr_out !== phy_addr_t'(m_rat[rs1]) ||
          busy_table_rd2_addr !== phy_addr_t'(m_rat[rs2]) || phy_rf_rs2_addr_out !== phy_addr_t'(m_rat[rs2])) begin
        bad++; $display("FAIL rand_src_%0d got=%0d/%0d want=%0d/%0d", i,
                        busy_table_rd1_addr, busy_table_rd2_addr, m_rat[rs1], m_rat[rs2]);
      end
      tick();
      {e_en, e_addr, e_cell} = exp_q.pop_front();
      total++;
      if (res_st_wr_en_out !== e_en || res_st_wr_addr_out !== e_addr || res_st_data_out !== e_cell) begin
        bad++; $display("FAIL rand_out_%0d got=%b/%0d/%h want=%b/%0d/%h", i,
                        res_st_wr_en_out, res_st_wr_addr_out, res_st_data_out, e_en, e_addr, e_cell);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst    = 1'b1;
    uop_in = '0;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_basic();
    test_same_reg();
    test_back_to_back_wrap();
    test_idle_and_zero();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rename.md
RENAME -- requirements
Module: rename

Interface
REQ-001 Constants (no module parameters; all come from qu_common):
- PHY_RF_ADDR_WIDTH, package value: physical register index width; P = 2^PHY_RF_ADDR_WIDTH physical registers; PHY_RF_ADDR_WIDTH >= 6.
- RES_ST_ADDR_WIDTH, package value: reservation-station index width (res_st_addr_t); R = 2^RES_ST_ADDR_WIDTH entries.
REQ-002 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-003 Ports, one per line:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  stage enable; rename uop_in this cycle.
- uop_in  in  uop_t  incoming uop; uses uop_ic.rd, uop_ic.rs1, uop_ic.rs2 (5-bit architectural indices).
- busy_table_rd1_addr  out  PHY_RF_ADDR_WIDTH  physical tag of rs1 to busy table.
- busy_table_data1_in  in  1  busy bit for rd1 address, same cycle.
- busy_table_rd2_addr  out  PHY_RF_ADDR_WIDTH  physical tag of rs2 to busy table.
- busy_table_data2_in  in  1  busy bit for rd2 address, same cycle.
- phy_rf_rs1_addr_out  out  PHY_RF_ADDR_WIDTH  physical tag of rs1 to register file.
- phy_rf_rs1_data_in  in  32  rs1 register value, same cycle.
- phy_rf_rs2_addr_out  out  PHY_RF_ADDR_WIDTH  physical tag of rs2 to register file.
- phy_rf_rs2_data_in  in  32  rs2 register value, same cycle.
- res_st_wr_en_out  out  1  reservation-station write strobe.
- res_st_wr_addr_out  out  res_st_addr_t  reservation-station entry index.
- res_st_data_out  out  res_st_cell_t  entry payload.
REQ-004 res_st_cell_t (qu_uop) carries: valid, uop, rd_phy, rs1_phy, rs2_phy, rs1_val[31:0], rs2_val[31:0], rs1_rdy, rs2_rdy.

Function
REQ-005 Rename map table (RAT): 32 entries x PHY_RF_ADDR_WIDTH, indexed by architectural register.
REQ-006 busy_table_rd1_addr = phy_rf_rs1_addr_out = RAT[uop_in.uop_ic.rs1], combinational from current RAT state; rs2 likewise.
REQ-007 Sources read RAT before this cycle's destination update (rs1 == rd in one uop yields the old mapping).
REQ-008 Allocation pointer alloc_ptr over [32, P-1]; uop with en=1 and rd != 0 receives rd_phy = alloc_ptr, RAT[rd] <= alloc_ptr, alloc_ptr increments, wrapping P-1 -> 32; no reclamation interface.
REQ-009 rd == 0: no allocation, RAT unchanged, rd_phy = 0; RAT[0] is constant 0.
REQ-010 Source index 0: rsX_val = 0, rsX_rdy = 1, regardless of inputs.
REQ-011 Other sources: rsX_val = phy_rf_rsX_data_in, rsX_rdy = !busy_table_dataX_in, sampled in the en cycle.
REQ-012 Latency one cycle: en=1 in cycle N -> cycle N+1 res_st_wr_en_out=1, res_st_data_out.valid=1, uop = uop_in, plus REQ-008..011 fields.
REQ-013 res_st_wr_addr_out = RS pointer; pointer increments per write, wraps R-1 -> 0; no backpressure; every en cycle writes.
REQ-014 en=0: RAT, alloc_ptr, RS pointer unchanged; next cycle res_st_wr_en_out=0, valid=0; other output registers hold.
REQ-015 Back-to-back: uop N+1 sources see RAT updated by uop N (RAT written on the edge between them).
REQ-016 Same rd in consecutive uops: each gets a new tag; RAT holds the latest.

Reset
REQ-017 rst=1 overrides en: RAT[i] = i for i in 0..31, alloc_ptr = 32, RS pointer = 0, res_st_wr_en_out = 0, res_st_wr_addr_out = 0, res_st_data_out = all zeros.
REQ-018 Reset mid-stream discards the in-flight uop; first uop after reset gets rd_phy 32 and RS address 0.

Verification (P=64)
REQ-019 Reset; rd=4 rs1=8 rs2=12, data 2/4, busy 0/0 -> rd1 addr 8, rd2 addr 12; next cycle wr_en=1, addr 0, rd_phy 32, rs1_phy 8, rs2_phy 12, vals 2/4, rdy 1/1.
REQ-020 Then rd=16 rs1=20 rs2=24, data 5/6 -> addr 1, rd_phy 33, vals 5/6; then rd=20 rs1=16, busy1=1 -> rd1 addr 33, addr 2, rd_phy 34, rs1_rdy 0.
REQ-021 rd=rs1=5 in one uop after reset -> rs1_phy 5, rd_phy 32; next uop rs1=5 -> rs1_phy 32.
REQ-022 33 consecutive uops with rd=1 after reset -> tags 32..63 then 32; RS addresses wrap at R-1 -> 0.
REQ-023 en=0 for 3 cycles -> wr_en 0, no allocation; rd=0 rs1=0 with data 7, busy 1 -> rd_phy 0, rs1_val 0, rs1_rdy 1.
